// File: rtl/rr_bus_arbiter_pkg.sv
// Shared types and sizing helpers for the round-robin bus arbiter.
package rr_bus_arbiter_pkg;

  typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_t;

  // Index width for n entries; never below one bit so single-bit ports stay legal.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_bus_arbiter_if.sv
// Master-facing and slave-facing bus signals of the arbiter, bundled as one interface.
interface rr_bus_arbiter_if
  import rr_bus_arbiter_pkg::*;
#(
  parameter int unsigned M_W = 4
) ();
  localparam int unsigned IDX_W = idx_w(M_W);

  logic [M_W-1:0]        bus_req;
  logic [M_W-1:0]        bus_lock;
  logic [M_W-1:0]        bus_grant;
  logic [IDX_W-1:0]      owner_idx;
  logic                  bus_busy;
  logic [M_W-1:0][31:0]  addr_m;
  logic [M_W-1:0][31:0]  rd_m;
  logic [M_W-1:0][31:0]  wd_m;
  logic [M_W-1:0]        we_m;
  logic [M_W-1:0][1:0]   size_m;
  logic [31:0]           addr_f;
  logic [31:0]           rd_f;
  logic [31:0]           wd_f;
  logic                  we_f;
  logic [1:0]            size_f;

  // Arbiter view.
  modport slave (
    input  bus_req, bus_lock, addr_m, wd_m, we_m, size_m, rd_f,
    output bus_grant, owner_idx, bus_busy, rd_m, addr_f, wd_f, we_f, size_f
  );

  // Masters plus slave fabric view.
  modport master (
    output bus_req, bus_lock, addr_m, wd_m, we_m, size_m, rd_f,
    input  bus_grant, owner_idx, bus_busy, rd_m, addr_f, wd_f, we_f, size_f
  );

endinterface

// File: rtl/rr_bus_arbiter_pick.sv
// Rotating priority search: first set request after start_i, wrapping, start_i itself last.
module rr_bus_arbiter_pick
  import rr_bus_arbiter_pkg::*;
#(
  parameter int unsigned M_W = 4,
  localparam int unsigned IDX_W = idx_w(M_W)
) (
  input  logic [M_W-1:0]   req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  int unsigned j;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int unsigned k = 1; k <= M_W; k++) begin
      j = (32'(start_i) + k) % M_W;
      if (!found_o && req_i[j[IDX_W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// N-master round-robin arbiter with owner lock, bounded unlocked tenure and slave-side mux.
module rr_bus_arbiter
  import rr_bus_arbiter_pkg::*;
#(
  parameter int unsigned M_W      = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  rr_bus_arbiter_if.slave bus
);

  localparam int unsigned IDX_W  = idx_w(M_W);
  localparam int unsigned HOLD_W = idx_w(MAX_HOLD + 1);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [M_W-1:0]    grant_q, grant_d;

  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic [M_W-1:0]    owner_mask;
  logic              others_req;
  logic              hold_ok;
  logic              keep;

  // ptr tracks the owner while OWNED, so one picker serves both idle arbitration and handover.
  rr_bus_arbiter_pick #(.M_W(M_W)) u_pick (
    .req_i   (bus.bus_req),
    .start_i (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    owner_mask          = '0;
    owner_mask[owner_q] = 1'b1;
    others_req = |(bus.bus_req & ~owner_mask);
    hold_ok    = (MAX_HOLD == 0) || ((32'(hold_q) + 1) < MAX_HOLD);
    keep       = (state_q == ARB_OWNED) && bus.bus_req[owner_q] &&
                 (bus.bus_lock[owner_q] || !others_req || hold_ok);
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    if (keep) begin
      if (hold_q != '1) hold_d = hold_q + 1'b1;
    end else if (pick_found) begin
      state_d           = ARB_OWNED;
      owner_d           = pick_idx;
      ptr_d             = pick_idx;
      hold_d            = '0;
      grant_d           = '0;
      grant_d[pick_idx] = 1'b1;
    end else begin
      state_d = ARB_IDLE;
      grant_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= IDX_W'(M_W - 1);
      hold_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
    end
  end

  assign bus.bus_grant = grant_q;
  assign bus.bus_busy  = (state_q == ARB_OWNED);
  assign bus.owner_idx = owner_q;
  assign bus.rd_m      = {M_W{bus.rd_f}};

  always_comb begin
    bus.addr_f = '0;
    bus.wd_f   = '0;
    bus.size_f = '0;
    bus.we_f   = 1'b0;
    if (state_q == ARB_OWNED) begin
      bus.addr_f = bus.addr_m[owner_q];
      bus.wd_f   = bus.wd_m[owner_q];
      bus.size_f = bus.size_m[owner_q];
      bus.we_f   = bus.we_m[owner_q];
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Scenario bench for rr_bus_arbiter (M_W=4, MAX_HOLD=8) with a queue of expected grants.
module tb_rr_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rr_bus_arbiter_if #(.M_W(4)) bif ();

  rr_bus_arbiter #(.M_W(4), .MAX_HOLD(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  typedef struct {
    logic [3:0] grant;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bif.bus_req  = '0;
    bif.bus_lock = '0;
    bif.we_m     = '0;
    bif.rd_f     = 32'hA5A5_0001;
    for (int i = 0; i < 4; i++) begin
      bif.addr_m[i] = 32'h1000_0000 + 32'(i * 16);
      bif.wd_m[i]   = 32'hCAFE_0000 + 32'(i);
      bif.size_m[i] = 2'(i);
    end
    exp_q.push_back('{grant: 4'b0000, busy: 1'b0});
    cycle();
    e = exp_q.pop_front();
    checks++;
    if (bif.bus_grant !== e.grant || bif.bus_busy !== e.busy) begin
      errors++;
      $display("FAIL reset_grant got=%b/%b exp=%b/%b", bif.bus_grant, bif.bus_busy, e.grant, e.busy);
    end
    checks++;
    if (bif.owner_idx !== 2'd0 || bif.we_f !== 1'b0 || bif.addr_f !== 32'h0) begin
      errors++;
      $display("FAIL reset_outs got owner=%0d we_f=%b addr_f=%h exp 0/0/0", bif.owner_idx, bif.we_f, bif.addr_f);
    end
  endtask

  task automatic test_single();
    rst         = 1'b0;
    bif.bus_req = 4'b0001;
    bif.we_m    = 4'b0001;
    exp_q.push_back('{grant: 4'b0001, busy: 1'b1});
    cycle();
    e = exp_q.pop_front();
    checks++;
    if (bif.bus_grant !== e.grant || bif.bus_busy !== e.busy) begin
      errors++;
      $display("FAIL single_grant got=%b/%b exp=%b/%b", bif.bus_grant, bif.bus_busy, e.grant, e.busy);
    end
    checks++;
    if (bif.we_f !== 1'b1 || bif.addr_f !== 32'h1000_0000 || bif.wd_f !== 32'hCAFE_0000 ||
        bif.size_f !== 2'd0 || bif.owner_idx !== 2'd0) begin
      errors++;
      $display("FAIL single_mux got we=%b addr=%h wd=%h size=%0d owner=%0d", bif.we_f, bif.addr_f,
               bif.wd_f, bif.size_f, bif.owner_idx);
    end
    checks++;
    if (bif.rd_m[2] !== 32'hA5A5_0001 || bif.rd_m[0] !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL rd_bcast got=%h/%h exp=a5a50001", bif.rd_m[0], bif.rd_m[2]);
    end
    // Lone requester is kept well past the hold limit.
    for (int c = 0; c < 20; c++) begin
      exp_q.push_back('{grant: 4'b0001, busy: 1'b1});
      cycle();
      e = exp_q.pop_front();
      checks++;
      if (bif.bus_grant !== e.grant || bif.bus_busy !== e.busy) begin
        errors++;
        $display("FAIL single_hold[%0d] got=%b exp=%b", c, bif.bus_grant, e.grant);
      end
    end
    bif.we_m = 4'b0000;
    #1;
    checks++;
    if (bif.we_f !== 1'b0) begin
      errors++;
      $display("FAIL single_we_drop got=%b exp=0", bif.we_f);
    end
  endtask

  task automatic test_rotation();
    rst = 1'b1;
    exp_q.push_back('{grant: 4'b0000, busy: 1'b0});
    cycle();
    e = exp_q.pop_front();
    checks++;
    if (bif.bus_grant !== e.grant) begin
      errors++;
      $display("FAIL rot_reset got=%b exp=%b", bif.bus_grant, e.grant);
    end
    rst         = 1'b0;
    bif.bus_req = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      logic [3:0] g;
      g = 4'b0001 << ((c / 8) % 4);
      exp_q.push_back('{grant: g, busy: 1'b1});
      cycle();
      e = exp_q.pop_front();
      checks++;
      if (bif.bus_grant !== e.grant || bif.bus_busy !== e.busy) begin
        errors++;
        $display("FAIL rotate[%0d] got=%b exp=%b", c, bif.bus_grant, e.grant);
      end
    end
  endtask

  task automatic test_lock();
    bif.bus_req = 4'b0000;
    exp_q.push_back('{grant: 4'b0000, busy: 1'b0});
    cycle();
    e = exp_q.pop_front();
    checks++;
    if (bif.bus_grant !== e.grant || bif.bus_busy !== e.busy) begin
      errors++;
      $display("FAIL lock_idle got=%b exp=%b", bif.bus_grant, e.grant);
    end
    bif.bus_req = 4'b0100;
    exp_q.push_back('{grant: 4'b0100, busy: 1'b1});
    cycle();
    e = exp_q.pop_front();
    checks++;
    if (bif.bus_grant !== e.grant) begin
      errors++;
      $display("FAIL lock_take got=%b exp=%b", bif.bus_grant, e.grant);
    end
    bif.bus_req  = 4'b1111;
    bif.bus_lock = 4'b0100;
    for (int c = 0; c < 40; c++) begin
      exp_q.push_back('{grant: 4'b0100, busy: 1'b1});
      cycle();
      e = exp_q.pop_front();
      checks++;
      if (bif.bus_grant !== e.grant) begin
        errors++;
        $display("FAIL lock_hold[%0d] got=%b exp=%b", c, bif.bus_grant, e.grant);
      end
    end
    bif.bus_lock = 4'b0000;
    exp_q.push_back('{grant: 4'b1000, busy: 1'b1});
    cycle();
    e = exp_q.pop_front();
    checks++;
    if (bif.bus_grant !== e.grant) begin
      errors++;
      $display("FAIL lock_release got=%b exp=%b", bif.bus_grant, e.grant);
    end
  endtask

  task automatic test_handover();
    bif.bus_req = 4'b0000;
    exp_q.push_back('{grant: 4'b0000, busy: 1'b0});
    cycle();
    e = exp_q.pop_front();
    checks++;
    if (bif.bus_grant !== e.grant || bif.bus_busy !== e.busy) begin
      errors++;
      $display("FAIL ho_idle got=%b exp=%b", bif.bus_grant, e.grant);
    end
    bif.bus_req = 4'b0010;
    exp_q.push_back('{grant: 4'b0010, busy: 1'b1});
    cycle();
    e = exp_q.pop_front();
    checks++;
    if (bif.bus_grant !== e.grant) begin
      errors++;
      $display("FAIL ho_take got=%b exp=%b", bif.bus_grant, e.grant);
    end
    bif.bus_req = 4'b0101;
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back('{grant: 4'b0100, busy: 1'b1});
      cycle();
      e = exp_q.pop_front();
      checks++;
      if (bif.bus_grant !== e.grant || bif.bus_busy !== e.busy || bif.owner_idx !== 2'd2) begin
        errors++;
        $display("FAIL ho_next[%0d] got=%b/%b owner=%0d exp=%b/%b owner=2", c, bif.bus_grant,
                 bif.bus_busy, bif.owner_idx, e.grant, e.busy);
      end
    end
  endtask

  task automatic test_idle();
    bif.we_m    = 4'b1111;
    bif.bus_req = 4'b0000;
    exp_q.push_back('{grant: 4'b0000, busy: 1'b0});
    cycle();
    e = exp_q.pop_front();
    checks++;
    if (bif.bus_grant !== e.grant || bif.bus_busy !== e.busy) begin
      errors++;
      $display("FAIL idle_grant got=%b/%b exp=%b/%b", bif.bus_grant, bif.bus_busy, e.grant, e.busy);
    end
    checks++;
    if (bif.we_f !== 1'b0 || bif.addr_f !== 32'h0 || bif.wd_f !== 32'h0 || bif.size_f !== 2'd0) begin
      errors++;
      $display("FAIL idle_slave got we=%b addr=%h wd=%h size=%0d exp all 0", bif.we_f, bif.addr_f,
               bif.wd_f, bif.size_f);
    end
  endtask

  task automatic test_reset_mid();
    bif.we_m    = 4'b1000;
    bif.bus_req = 4'b1000;
    exp_q.push_back('{grant: 4'b1000, busy: 1'b1});
    cycle();
    e = exp_q.pop_front();
    checks++;
    if (bif.bus_grant !== e.grant || bif.we_f !== 1'b1 || bif.addr_f !== 32'h1000_0030 ||
        bif.size_f !== 2'd3) begin
      errors++;
      $display("FAIL rm_write got=%b we=%b addr=%h size=%0d exp=%b/1/10000030/3", bif.bus_grant,
               bif.we_f, bif.addr_f, bif.size_f, e.grant);
    end
    rst = 1'b1;
    exp_q.push_back('{grant: 4'b0000, busy: 1'b0});
    cycle();
    e = exp_q.pop_front();
    checks++;
    if (bif.bus_grant !== e.grant || bif.bus_busy !== e.busy || bif.we_f !== 1'b0) begin
      errors++;
      $display("FAIL rm_reset got=%b/%b we=%b exp=%b/%b we=0", bif.bus_grant, bif.bus_busy,
               bif.we_f, e.grant, e.busy);
    end
    rst         = 1'b0;
    bif.bus_req = 4'b1111;
    exp_q.push_back('{grant: 4'b0001, busy: 1'b1});
    cycle();
    e = exp_q.pop_front();
    checks++;
    if (bif.bus_grant !== e.grant || bif.bus_busy !== e.busy) begin
      errors++;
      $display("FAIL rm_first got=%b exp=%b", bif.bus_grant, e.grant);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_lock();
    test_handover();
    test_idle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
